sparse_pair_encoder: RTL

- Front-end compressor for the sparse dot-product datapath.
- Accepts one dense operand pair (Vector_A, Vector_B, N lanes of W bits) through a valid/ready handshake.
- Drops every lane where either operand is zero.
- Streams the surviving (index, a, b) triples one per handshake to a serial MAC or link, so downstream work scales with the nonzero-pair count instead of N.

---
 rtl/sparse_pair_encoder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/sparse_pair_encoder.sv
// sparse_pair_encoder
//   Front-end compressor for the sparse dot-product datapath. Captures one
//   dense operand pair, drops every lane where either operand is zero, and
//   streams the surviving (index, a, b) triples in ascending index order,
//   one per output handshake. A vector with no surviving lanes produces a
//   single null token flagged by out_empty.
//
//   State table:
//     IDLE | waiting for a vector pair; in_ready high (outside reset)
//     EMIT | vector captured; presenting tokens until the last is accepted
//
// Ports:
//   clk, rst             rising-edge clock, asynchronous active-low reset
//   in_valid/in_ready    input handshake for Vector_A / Vector_B
//   Vector_A, Vector_B   N lanes of W-bit unsigned operands, lane i at [i*W +: W]
//   out_valid/out_ready  output token handshake
//   out_idx, out_a, out_b  token payload
//   out_last             final token of the current vector
//   out_empty            null token (vector had no nonzero pairs)
//   pair_count           nonzero-pair count of the current/most recent vector
//   busy                 a vector is captured and not fully emitted
module sparse_pair_encoder #(
  parameter int N    = 16,
  parameter int W    = 8,
  parameter int IDXW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N*W-1:0]    Vector_A,
  input  logic [N*W-1:0]    Vector_B,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [IDXW-1:0]   out_idx,
  output logic [W-1:0]      out_a,
  output logic [W-1:0]      out_b,
  output logic              out_last,
  output logic              out_empty,
  output logic [IDXW:0]     pair_count,
  output logic              busy
);

  localparam int CW = IDXW + 1;

  typedef enum logic {IDLE, EMIT} state_t;

  state_t             state, state_nxt;
  logic [N*W-1:0]     a_q, b_q;
  logic [N-1:0]       mask_q;

  logic               capture, advance, load_tok, clear_tok;
  logic [N-1:0]       in_mask, sel_mask, cur_bit;
  logic [N*W-1:0]     sel_a, sel_b;
  logic [IDXW-1:0]    sel_k;
  logic [W-1:0]       tok_a, tok_b;
  logic               sel_any, sel_single;
  logic [CW-1:0]      in_count;

  // in_ready is gated by rst so it reads low for the whole reset interval.
  assign in_ready  = (state == IDLE) && rst;
  assign out_valid = (state == EMIT);
  assign busy      = (state == EMIT);
  assign capture   = in_valid && in_ready;
  assign advance   = out_valid && out_ready;
  assign load_tok  = capture || (advance && !out_last);
  assign clear_tok = advance && out_last;

  always_comb begin
    in_mask  = '0;
    in_count = '0;
    for (int i = 0; i < N; i++) begin
      in_mask[i] = (Vector_A[i*W +: W] != '0) && (Vector_B[i*W +: W] != '0);
      in_count   = in_count + CW'(in_mask[i]);
    end
  end

  // The token registers are loaded with the *next* token, so the select
  // works on the incoming vector at capture and on the captured vector with
  // the current bit removed while emitting. Outputs are therefore plain flops.
  assign cur_bit = {{(N-1){1'b0}}, 1'b1} << out_idx;

  always_comb begin
    if (state == IDLE) begin
      sel_mask = in_mask;
      sel_a    = Vector_A;
      sel_b    = Vector_B;
    end else begin
      sel_mask = mask_q & ~cur_bit;
      sel_a    = a_q;
      sel_b    = b_q;
    end
  end

  // Lowest-set-bit select; scanning downward leaves the lowest hit last.
  // An empty mask leaves index and lane data at zero for the null token.
  always_comb begin
    sel_k = '0;
    tok_a = '0;
    tok_b = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (sel_mask[i]) begin
        sel_k = IDXW'(i);
        tok_a = sel_a[i*W +: W];
        tok_b = sel_b[i*W +: W];
      end
    end
  end

  assign sel_any    = |sel_mask;
  assign sel_single = sel_any &&
                      ((sel_mask & (sel_mask - {{(N-1){1'b0}}, 1'b1})) == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (capture) state_nxt = EMIT;
      EMIT:    if (clear_tok) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_q        <= '0;
      b_q        <= '0;
      mask_q     <= '0;
      pair_count <= '0;
      out_idx    <= '0;
      out_a      <= '0;
      out_b      <= '0;
      out_last   <= 1'b0;
      out_empty  <= 1'b0;
    end else begin
      if (capture) begin
        a_q        <= Vector_A;
        b_q        <= Vector_B;
        pair_count <= in_count;
      end
      if (load_tok) begin
        mask_q    <= sel_mask;
        out_idx   <= sel_k;
        out_a     <= tok_a;
        out_b     <= tok_b;
        out_last  <= !sel_any || sel_single;
        out_empty <= !sel_any;
      end else if (clear_tok) begin
        mask_q    <= '0;
        out_idx   <= '0;
        out_a     <= '0;
        out_b     <= '0;
        out_last  <= 1'b0;
        out_empty <= 1'b0;
      end
    end
  end

endmodule
